vga_dac_port_fml: RTL and testbench
===================================

# vga_dac_port_fml

CPU-side port controller for the VGA DAC palette register file. It decodes the four VGA DAC I/O ports: 3C6 pixel mask, 3C7 read index / DAC state, 3C8 write index, 3C9 data. It sequences the red/green/blue cycle counters and auto-increments the palette index, driving the DAC register file's CPU read and write interfaces. It sits between the VGA I/O decoder and the DAC register file, in the same clock domain as both.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- io_stb  in  1  access request; held until io_ack
- io_we  in  1  1 = write, 0 = read; qualified by io_stb
- io_addr  in  2  0 = 3C6, 1 = 3C7, 2 = 3C8, 3 = 3C9
- io_wdat  in  8  CPU write data
- io_rdat  out  8  CPU read data; valid while io_ack = 1
- io_ack  out  1  one-cycle completion pulse
- pel_mask  out  8  pixel mask register, to the VGA pixel path
- write  out  1  DAC write strobe, one cycle per 3C9 write
- write_data_cycle  out  2  colour component for the write: 0 = R, 1 = G, 2 = B
- write_data_register  out  8  palette index for the write
- write_data  out  4  component value: io_wdat[5:2]
- read_data_cycle  out  2  live read component counter
- read_data_register  out  8  live read palette index
- read_data  in  4  DAC read data; registered in the DAC, valid 1 cycle after cycle/register change

## Operation
- Internal state:
  - wr_reg[7:0], wr_cyc[1:0]: write index and write component counter.
  - rd_reg[7:0], rd_cyc[1:0]: read index and read component counter, driven directly on read_data_register / read_data_cycle.
  - rd_mode flag.
  - pel_mask.
- FSM states: IDLE, RD_W0, RD_W1, ACK.
  - An access is accepted only in IDLE with io_stb = 1.
  - A 3C9 read goes IDLE → RD_W0 → RD_W1 → ACK.
  - All other accesses go IDLE → ACK.
  - ACK always returns to IDLE.
  - io_stb outside IDLE is ignored.
- Writes:
  - 3C6: pel_mask ← io_wdat.
  - 3C7: rd_reg ← io_wdat, rd_cyc ← 0, rd_mode ← 1.
  - 3C8: wr_reg ← io_wdat, wr_cyc ← 0, rd_mode ← 0.
  - 3C9: write, write_data_cycle, write_data_register and write_data are loaded from the pre-increment wr_cyc, wr_reg and io_wdat[5:2], with write = 1 for exactly one cycle. wr_cyc then advances 0→1→2→0. On 2→0, wr_reg increments modulo 256 (FF→00).
- Reads:
  - 3C6 returns pel_mask.
  - 3C7 returns {6'b0, rd_mode, rd_mode}: 00 = write mode, 11 = read mode.
  - 3C8 returns wr_reg.
  - 3C9 captures {2'b00, read_data, 2'b00} in RD_W1, then advances rd_cyc/rd_reg with the same wrap rules as the write side.
- wr_cyc and rd_cyc never hold the value 3.

## Timing
- Acceptance cycle T: io_ack = 1 during cycle T+1 for every access except 3C9 read, where io_ack = 1 during T+3.
- io_rdat is registered, valid during the io_ack cycle, and holds its value until the next read completes.
- 3C9 write: write = 1 during cycle T+1. The new wr_cyc/wr_reg are visible from T+1.
- 3C9 read: read_data is sampled at the end of T+2. rd_cyc/rd_reg update at that same edge. Two wait cycles guarantee the DAC's 1-cycle read latency is met even directly after a 3C7 write.
- Back-to-back: the earliest next acceptance is the cycle after io_ack.
- Reset (async, any state, including mid-read): FSM → IDLE; io_ack, write and io_rdat ← 0; all counters and indices ← 0; rd_mode ← 0; pel_mask ← 8'hFF. An interrupted access is dropped with no ack and no DAC write.

## Configuration
- VGA_DAC_PEL_MASK_EN
  - Defined: pel_mask is a writable register as described, reset 8'hFF.
  - Undefined: pel_mask is constant 8'hFF, 3C6 writes are acked but ignored, and 3C6 reads return 8'hFF.

## Test plan
- Write 3C8 = 0x10, then 3C9 = 0x3F, 0x00, 0x20 → three write pulses with (cycle, reg, data) = (0,10,F), (1,10,0), (2,10,8); a 3C8 read then returns 0x11.
- Write 3C8 = 0xFF, three 3C9 writes → reg FF used for all three; 3C8 read returns 0x00 (wrap).
- DAC model preloaded with index 5 = (0xA, 0x3, 0xC); write 3C7 = 0x05, three 3C9 reads → io_rdat 0x28, 0x0C, 0x30, each acked at T+3; read_data_register = 0x06 afterwards.
- 3C7 reads: after a 3C7 write returns 0x03; after a 3C8 write returns 0x00. 3C6 write 0x0F then read → 0x0F, or 0xFF with VGA_DAC_PEL_MASK_EN undefined.
- Hold io_stb high through ack → exactly one ack per access; the next access is accepted only the cycle after ack.
- Assert rst_n low during RD_W0 of a 3C9 read → no ack; rd_reg = 0, pel_mask = 0xFF; the next access behaves normally.

Source files
------------

// File: rtl/vga_dac_port_fml.sv
// -----------------------------------------------------------------------------
// vga_dac_port_fml
//
// CPU-side port controller for the VGA DAC palette register file. Decodes the
// four DAC I/O ports (3C6 pixel mask, 3C7 read index / DAC state, 3C8 write
// index, 3C9 data), sequences the R/G/B component counters with palette index
// auto-increment, and drives the DAC register file's CPU read/write ports.
//
// Optional feature macro: VGA_DAC_PEL_MASK_EN
//   defined   : pel_mask is a CPU-writable register (reset 8'hFF)
//   undefined : pel_mask is tied to 8'hFF; 3C6 writes are acked and dropped
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   io_stb, io_we         CPU access request / direction (1 = write)
//   io_addr[1:0]          0 = 3C6, 1 = 3C7, 2 = 3C8, 3 = 3C9
//   io_wdat[7:0]          CPU write data
//   io_rdat[7:0]          CPU read data, registered, valid while io_ack = 1
//   io_ack                one-cycle completion pulse
//   pel_mask[7:0]         pixel mask to the VGA pixel path
//   write                 DAC write strobe (one cycle per 3C9 write)
//   write_data_cycle[1:0] component for the write (0 = R, 1 = G, 2 = B)
//   write_data_register   palette index for the write
//   write_data[3:0]       component value (io_wdat[5:2])
//   read_data_cycle[1:0]  live read component counter
//   read_data_register    live read palette index
//   read_data[3:0]        DAC read data, one cycle after cycle/register change
//
// Handshake: an access is a request held on io_stb; it is accepted only when
// the FSM is in IDLE, and completes with a single-cycle io_ack. io_stb seen in
// any other state is ignored, so a CPU that keeps io_stb high through io_ack
// cannot start a second access until the cycle after the ack.
// -----------------------------------------------------------------------------
module vga_dac_port_fml (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_stb,
    input  logic       io_we,
    input  logic [1:0] io_addr,
    input  logic [7:0] io_wdat,
    output logic [7:0] io_rdat,
    output logic       io_ack,
    output logic [7:0] pel_mask,
    output logic       write,
    output logic [1:0] write_data_cycle,
    output logic [7:0] write_data_register,
    output logic [3:0] write_data,
    output logic [1:0] read_data_cycle,
    output logic [7:0] read_data_register,
    input  logic [3:0] read_data
);

    localparam logic [1:0] PORT_MASK  = 2'd0;
    localparam logic [1:0] PORT_RDIDX = 2'd1;
    localparam logic [1:0] PORT_WRIDX = 2'd2;
    localparam logic [1:0] PORT_DATA  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_W0 = 2'd1,
        RD_W1 = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       accept;

    logic [7:0] wr_reg;
    logic [1:0] wr_cyc;
    logic [7:0] rd_reg;
    logic [1:0] rd_cyc;
    logic       rd_mode;

    // Component counters run 0 -> 1 -> 2 -> 0; value 3 is never produced.
    function automatic logic [1:0] next_cyc(input logic [1:0] cyc);
        return (cyc == 2'd2) ? 2'd0 : cyc + 2'd1;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (io_stb) begin
                    // Only a 3C9 read needs the DAC, so only it takes the
                    // two wait states covering the DAC's registered read.
                    if (!io_we && io_addr == PORT_DATA) begin
                        next_state = RD_W0;
                    end else begin
                        next_state = ACK;
                    end
                end
            end
            RD_W0:   next_state = RD_W1;
            RD_W1:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept = (state == IDLE) && io_stb;
        io_ack = (state == ACK);
    end

    assign read_data_cycle    = rd_cyc;
    assign read_data_register = rd_reg;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdat             <= 8'h00;
            write               <= 1'b0;
            write_data_cycle    <= 2'd0;
            write_data_register <= 8'h00;
            write_data          <= 4'h0;
            wr_reg              <= 8'h00;
            wr_cyc              <= 2'd0;
            rd_reg              <= 8'h00;
            rd_cyc              <= 2'd0;
            rd_mode             <= 1'b0;
        end else begin
            write <= 1'b0;

            if (accept) begin
                if (io_we) begin
                    case (io_addr)
                        PORT_RDIDX: begin
                            rd_reg  <= io_wdat;
                            rd_cyc  <= 2'd0;
                            rd_mode <= 1'b1;
                        end
                        PORT_WRIDX: begin
                            wr_reg  <= io_wdat;
                            wr_cyc  <= 2'd0;
                            rd_mode <= 1'b0;
                        end
                        PORT_DATA: begin
                            // DAC sees the pre-increment index/component.
                            write               <= 1'b1;
                            write_data_cycle    <= wr_cyc;
                            write_data_register <= wr_reg;
                            write_data          <= io_wdat[5:2];
                            wr_cyc              <= next_cyc(wr_cyc);
                            if (wr_cyc == 2'd2) begin
                                wr_reg <= wr_reg + 8'd1;
                            end
                        end
                        default: ; // 3C6 handled in the pel_mask block
                    endcase
                end else begin
                    case (io_addr)
                        PORT_MASK:  io_rdat <= pel_mask;
                        PORT_RDIDX: io_rdat <= {6'b0, rd_mode, rd_mode};
                        PORT_WRIDX: io_rdat <= wr_reg;
                        default:    ; // 3C9 read completes in RD_W1
                    endcase
                end
            end

            // 6-bit DAC byte layout: 4-bit component sits in bits [5:2].
            if (state == RD_W1) begin
                io_rdat <= {2'b00, read_data, 2'b00};
                rd_cyc  <= next_cyc(rd_cyc);
                if (rd_cyc == 2'd2) begin
                    rd_reg <= rd_reg + 8'd1;
                end
            end
        end
    end

    // ---------------- Pixel mask ----------------
`ifdef VGA_DAC_PEL_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pel_mask <= 8'hFF;
        end else if (accept && io_we && io_addr == PORT_MASK) begin
            pel_mask <= io_wdat;
        end
    end
`else
    assign pel_mask = 8'hFF;
`endif

endmodule

// File: tb/tb_vga_dac_port_fml.sv
// -----------------------------------------------------------------------------
// tb_vga_dac_port_fml
//
// Bench for vga_dac_port_fml. Contains a DAC register file stub, a reference
// model of the port controller kept as linear palette positions
// (index * 3 + component), driver tasks, a per-cycle compare process and a
// final report.
// -----------------------------------------------------------------------------
module tb_vga_dac_port_fml;

    logic       clk;
    logic       rst_n;
    logic       io_stb;
    logic       io_we;
    logic [1:0] io_addr;
    logic [7:0] io_wdat;
    logic [7:0] io_rdat;
    logic       io_ack;
    logic [7:0] pel_mask;
    logic       write;
    logic [1:0] write_data_cycle;
    logic [7:0] write_data_register;
    logic [3:0] write_data;
    logic [1:0] read_data_cycle;
    logic [7:0] read_data_register;
    logic [3:0] read_data;

    vga_dac_port_fml dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .io_stb              (io_stb),
        .io_we               (io_we),
        .io_addr             (io_addr),
        .io_wdat             (io_wdat),
        .io_rdat             (io_rdat),
        .io_ack              (io_ack),
        .pel_mask            (pel_mask),
        .write               (write),
        .write_data_cycle    (write_data_cycle),
        .write_data_register (write_data_register),
        .write_data          (write_data),
        .read_data_cycle     (read_data_cycle),
        .read_data_register  (read_data_register),
        .read_data           (read_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DAC register file stub ----------------
    logic [3:0] pal [0:767];
    initial begin
        for (int i = 0; i < 768; i++) pal[i] = 4'h0;
        pal[15] = 4'hA;  // index 5: R
        pal[16] = 4'h3;  // index 5: G
        pal[17] = 4'hC;  // index 5: B
        read_data = 4'h0;
        forever begin
            @(posedge clk);
            if (write)
                pal[int'(write_data_register) * 3 + int'(write_data_cycle)] <= write_data;
            read_data <= pal[int'(read_data_register) * 3 + int'(read_data_cycle)];
        end
    end

    // ---------------- reference model ----------------
    logic [3:0] m_pal [0:767];
    int         m_wr_idx;   // write position = index * 3 + component
    int         m_rd_idx;   // read position
    logic       m_rd_mode;
    logic [7:0] m_pel;
    logic       busy;       // access or reset in progress: model not settled

    // Expected DAC writes: {component, index, data}
    logic [13:0] exp_q[$];

    task automatic model_reset();
        m_wr_idx  = 0;
        m_rd_idx  = 0;
        m_rd_mode = 1'b0;
        m_pel     = 8'hFF;
    endtask

    initial begin
        for (int i = 0; i < 768; i++) m_pal[i] = 4'h0;
        m_pal[15] = 4'hA;
        m_pal[16] = 4'h3;
        m_pal[17] = 4'hC;
        model_reset();
        busy = 1'b1;
    end

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge of the ack cycle
    // with io_stb already dropped. extra = cycles the DUT is expected to be
    // busy before it can accept (1 when issued in the previous ack cycle).
    task automatic access(input logic we, input logic [1:0] addr, input logic [7:0] wdat,
                          input int extra, output logic [7:0] rdat);
        int         n;
        int         lat;
        logic [7:0] exp_r;
        logic [1:0] e_cyc;
        logic [7:0] e_reg;
        logic [3:0] e_val;
        exp_r = 8'h00;
        lat   = (!we && addr == 2'd3) ? 3 : 1;
        if (we && addr == 2'd3) begin
            e_cyc = 2'(m_wr_idx % 3);
            e_reg = 8'(m_wr_idx / 3);
            e_val = wdat[5:2];
            exp_q.push_back({e_cyc, e_reg, e_val});
        end
        if (!we) begin
            case (addr)
                2'd0: exp_r = m_pel;
                2'd1: exp_r = {6'b0, m_rd_mode, m_rd_mode};
                2'd2: exp_r = 8'(m_wr_idx / 3);
                default: begin
                    e_val = m_pal[m_rd_idx];
                    exp_r = {2'b00, e_val, 2'b00};
                end
            endcase
        end
        busy    = 1'b1;
        io_stb  = 1'b1;
        io_we   = we;
        io_addr = addr;
        io_wdat = wdat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io_ack && n < 12);
        chk("ack_latency", n, lat + extra);
        chk("write_at_ack", {31'b0, write}, {31'b0, we && addr == 2'd3});
        if (!we) chk("read_value", io_rdat, exp_r);
        rdat   = io_rdat;
        io_stb = 1'b0;
        // model update
        if (we) begin
            case (addr)
                2'd0: begin
`ifdef VGA_DAC_PEL_MASK_EN
                    m_pel = wdat;
`endif
                end
                2'd1: begin m_rd_idx = int'(wdat) * 3; m_rd_mode = 1'b1; end
                2'd2: begin m_wr_idx = int'(wdat) * 3; m_rd_mode = 1'b0; end
                default: begin
                    m_pal[m_wr_idx] = wdat[5:2];
                    m_wr_idx = (m_wr_idx + 1) % 768;
                end
            endcase
        end else if (addr == 2'd3) begin
            m_rd_idx = (m_rd_idx + 1) % 768;
        end
        busy = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // ---------------- compare process ----------------
    logic prev_ack = 1'b0;
    initial begin
        logic [13:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (io_ack) chk("single_ack", {31'b0, prev_ack}, 32'd0);
                if (write) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_fields",
                            {18'b0, write_data_cycle, write_data_register, write_data},
                            {18'b0, e});
                    end
                end
                if (!busy) begin
                    chk("rd_register", read_data_register, 32'(m_rd_idx / 3));
                    chk("rd_cycle", read_data_cycle, 32'(m_rd_idx % 3));
                    chk("pel_mask", pel_mask, m_pel);
                    chk("idle_no_write", {31'b0, write}, 32'd0);
                end
            end
            prev_ack = io_ack;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [7:0] r;
    logic [7:0] exp_mask;

    initial begin
        rst_n   = 1'b0;
        io_stb  = 1'b0;
        io_we   = 1'b0;
        io_addr = 2'd0;
        io_wdat = 8'h00;
`ifdef VGA_DAC_PEL_MASK_EN
        exp_mask = 8'h0F;
`else
        exp_mask = 8'hFF;
`endif
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_io_ack", {31'b0, io_ack}, 32'd0);
        chk("rst_write", {31'b0, write}, 32'd0);
        chk("rst_io_rdat", io_rdat, 32'h00);
        chk("rst_pel_mask", pel_mask, 32'hFF);
        chk("rst_rd_register", read_data_register, 32'h00);
        chk("rst_rd_cycle", read_data_cycle, 32'd0);
        chk("rst_wr_fields", {write_data_cycle, write_data_register, write_data}, 32'd0);
        rst_n = 1'b1;
        busy  = 1'b0;
        idle(2);

        // Write index 0x10, three components
        access(1'b1, 2'd2, 8'h10, 0, r);
        idle(1);
        access(1'b1, 2'd3, 8'h3F, 0, r);
        idle(1);
        access(1'b1, 2'd3, 8'h00, 0, r);
        idle(1);
        access(1'b1, 2'd3, 8'h20, 0, r);
        idle(2);
        chk("pal_10_r", pal[48], 32'hF);
        chk("pal_10_g", pal[49], 32'h0);
        chk("pal_10_b", pal[50], 32'h8);
        access(1'b0, 2'd2, 8'h00, 0, r);
        chk("wr_index_after_3", r, 32'h11);
        idle(1);

        // Write index 0xFF, wrap to 0x00 (back-to-back accesses)
        access(1'b1, 2'd2, 8'hFF, 0, r);
        access(1'b1, 2'd3, 8'h04, 1, r);
        access(1'b1, 2'd3, 8'h08, 1, r);
        access(1'b1, 2'd3, 8'h0C, 1, r);
        idle(2);
        chk("pal_ff_b", pal[767], 32'h3);
        access(1'b0, 2'd2, 8'h00, 0, r);
        chk("wr_index_wrap", r, 32'h00);
        idle(1);

        // Read index 5; first 3C9 read directly after the 3C7 write
        access(1'b1, 2'd1, 8'h05, 0, r);
        access(1'b0, 2'd3, 8'h00, 1, r);
        chk("rd_red", r, 32'h28);
        idle(1);
        access(1'b0, 2'd3, 8'h00, 0, r);
        chk("rd_green", r, 32'h0C);
        idle(1);
        access(1'b0, 2'd3, 8'h00, 0, r);
        chk("rd_blue", r, 32'h30);
        idle(2);
        chk("rd_register_after", read_data_register, 32'h06);

        // DAC state
        access(1'b0, 2'd1, 8'h00, 0, r);
        chk("dac_state_read", r, 32'h03);
        idle(1);
        access(1'b1, 2'd2, 8'h00, 0, r);
        idle(1);
        access(1'b0, 2'd1, 8'h00, 0, r);
        chk("dac_state_write", r, 32'h00);
        idle(1);

        // Pixel mask
        access(1'b1, 2'd0, 8'h0F, 0, r);
        idle(1);
        access(1'b0, 2'd0, 8'h00, 0, r);
        chk("pel_read", r, exp_mask);
        chk("pel_out", pel_mask, exp_mask);
        idle(1);

        // Move the read index away from zero, then reset during RD_W0
        access(1'b1, 2'd1, 8'h33, 0, r);
        idle(1);
        busy    = 1'b1;
        io_stb  = 1'b1;
        io_we   = 1'b0;
        io_addr = 2'd3;
        @(negedge clk);          // accepted at the previous edge: now RD_W0
        io_stb = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_ack", {31'b0, io_ack}, 32'd0);
        chk("mid_rst_rd_register", read_data_register, 32'h00);
        chk("mid_rst_pel_mask", pel_mask, 32'hFF);
        chk("mid_rst_io_rdat", io_rdat, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ack_after_rst", {31'b0, io_ack}, 32'd0);
            chk("no_write_after_rst", {31'b0, write}, 32'd0);
        end
        busy = 1'b0;
        idle(1);

        // Normal operation after reset
        access(1'b0, 2'd1, 8'h00, 0, r);
        chk("post_rst_state", r, 32'h00);
        idle(1);
        access(1'b0, 2'd0, 8'h00, 0, r);
        chk("post_rst_pel", r, 32'hFF);
        idle(1);
        access(1'b1, 2'd1, 8'h05, 0, r);
        idle(1);
        access(1'b0, 2'd3, 8'h00, 0, r);
        chk("post_rst_red", r, 32'h28);
        idle(3);

        chk("write_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
